// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared command codes and sequencer state encodings for the pipeline execution controller.
package pipeline_exec_ctrl_pkg;
    localparam int NB_CMD = 8;

    localparam logic [NB_CMD-1:0] CMD_RUN   = 8'h52;
    localparam logic [NB_CMD-1:0] CMD_STEP  = 8'h53;
    localparam logic [NB_CMD-1:0] CMD_FLUSH = 8'h46;
    localparam logic [NB_CMD-1:0] CMD_ABORT = 8'h41;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_HALTED = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;
endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Command byte handshake, WB halt flag and pipeline control/debug outputs of the execution controller.
interface pipeline_exec_ctrl_if
    import pipeline_exec_ctrl_pkg::*;
#(
    parameter int NB_CYC = 32
);
    logic              cmd_vld;
    logic [NB_CMD-1:0] cmd_dat;
    logic              cmd_rdy;
    logic              halt_wb;
    logic              pipe_enable;
    logic              pipe_flush;
    logic [2:0]        state;
    logic [NB_CYC-1:0] cycle_count;
    logic              done;

    modport master (
        output cmd_vld, cmd_dat, halt_wb,
        input  cmd_rdy, pipe_enable, pipe_flush, state, cycle_count, done
    );

    modport slave (
        input  cmd_vld, cmd_dat, halt_wb,
        output cmd_rdy, pipe_enable, pipe_flush, state, cycle_count, done
    );
endinterface

// File: rtl/pipeline_exec_ctrl_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after the enabling edge; no backpressure.
module pipeline_exec_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_exec_ctrl.sv
// Run/step/flush sequencer owning the global pipeline enable and flush, stopping on HALT in WB.
// Latency: outputs registered from next state (one cycle after command); cmd_rdy low in STEP/FLUSH.
module pipeline_exec_ctrl
    import pipeline_exec_ctrl_pkg::*;
#(
    parameter int NB_CYC       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_exec_ctrl_if.slave  bus
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_t        st;
    state_t        nxt;
    logic [FW-1:0] fcnt;
    logic          acc;
    logic          halt_seen;
    logic          cnt_clr;

    assign bus.cmd_rdy = rst_n && ((st == ST_IDLE) || (st == ST_RUN) || (st == ST_HALTED));
    assign acc         = bus.cmd_vld && bus.cmd_rdy;
    // The WB halt flag is only meaningful while instructions are actually advancing.
    assign halt_seen   = bus.pipe_enable && bus.halt_wb;
    assign cnt_clr     = (nxt == ST_FLUSH) && (st != ST_FLUSH);
    assign bus.state   = st;

    always_comb begin
        nxt = st;
        case (st)
            ST_IDLE: begin
                if (acc) begin
                    case (bus.cmd_dat)
                        CMD_RUN:   nxt = ST_RUN;
                        CMD_STEP:  nxt = ST_STEP;
                        CMD_FLUSH: nxt = ST_FLUSH;
                        default:   nxt = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (halt_seen) begin
                    nxt = ST_HALTED;
                end else if (acc && (bus.cmd_dat == CMD_ABORT)) begin
                    nxt = ST_IDLE;
                end
            end
            ST_STEP:   nxt = halt_seen ? ST_HALTED : ST_IDLE;
            ST_HALTED: if (acc && (bus.cmd_dat == CMD_FLUSH)) nxt = ST_FLUSH;
            ST_FLUSH:  if (fcnt == FLUSH_LAST) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st              <= ST_IDLE;
            fcnt            <= '0;
            bus.pipe_enable <= 1'b0;
            bus.pipe_flush  <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            st              <= nxt;
            fcnt            <= (st == ST_FLUSH) ? fcnt + 1'b1 : '0;
            bus.pipe_enable <= (nxt == ST_RUN) || (nxt == ST_STEP);
            bus.pipe_flush  <= (nxt == ST_FLUSH);
            bus.done        <= ((nxt == ST_HALTED) && (st != ST_HALTED)) ||
                               ((st == ST_STEP) && (nxt == ST_IDLE));
        end
    end

    pipeline_exec_ctrl_sat_counter #(.W(NB_CYC)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.pipe_enable),
        .clr   (cnt_clr),
        .cnt   (bus.cycle_count)
    );
endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed bench for the execution sequencer: reset, step, run/halt, flush, abort, saturation, async reset.
module tb_pipeline_exec_ctrl;
    import pipeline_exec_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipeline_exec_ctrl_if #(.NB_CYC(4)) bus ();

    pipeline_exec_ctrl #(.NB_CYC(4), .FLUSH_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Present a command for one edge; returns 1 time unit after that edge.
    task automatic send(input logic [7:0] c);
        bus.cmd_vld = 1'b1;
        bus.cmd_dat = c;
        @(posedge clk); #1;
        bus.cmd_vld = 1'b0;
        bus.cmd_dat = 8'h00;
    endtask

    task automatic test_reset();
        bus.cmd_vld = 1'b0; bus.cmd_dat = 8'h00; bus.halt_wb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0d exp=0", bus.cmd_rdy); end
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL idle_state got=%0d exp=0", bus.state); end
        total++; if (bus.pipe_enable !== 1'b0) begin bad++; $display("FAIL idle_enable got=%0d exp=0", bus.pipe_enable); end
        total++; if (bus.pipe_flush !== 1'b0) begin bad++; $display("FAIL idle_flush got=%0d exp=0", bus.pipe_flush); end
        total++; if (bus.cycle_count !== 4'd0) begin bad++; $display("FAIL idle_count got=%0d exp=0", bus.cycle_count); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL idle_done got=%0d exp=0", bus.done); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL idle_ready got=%0d exp=1", bus.cmd_rdy); end
    endtask

    task automatic test_step();
        for (int i = 0; i < 3; i++) begin
            send(CMD_STEP);
            total++; if (bus.state !== 3'd2) begin bad++; $display("FAIL step%0d_state got=%0d exp=2", i, bus.state); end
            total++; if (bus.pipe_enable !== 1'b1) begin bad++; $display("FAIL step%0d_enable got=%0d exp=1", i, bus.pipe_enable); end
            total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL step%0d_ready got=%0d exp=0", i, bus.cmd_rdy); end
            @(posedge clk); #1;
            total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL step%0d_back got=%0d exp=0", i, bus.state); end
            total++; if (bus.pipe_enable !== 1'b0) begin bad++; $display("FAIL step%0d_enoff got=%0d exp=0", i, bus.pipe_enable); end
            total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL step%0d_done got=%0d exp=1", i, bus.done); end
            @(posedge clk); #1;
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL step%0d_doneoff got=%0d exp=0", i, bus.done); end
        end
        total++; if (bus.cycle_count !== 4'd3) begin bad++; $display("FAIL step_count got=%0d exp=3", bus.cycle_count); end
    endtask

    task automatic test_flush_idle();
        send(CMD_FLUSH);
        total++; if (bus.state !== 3'd4) begin bad++; $display("FAIL fidle_state got=%0d exp=4", bus.state); end
        total++; if (bus.cycle_count !== 4'd0) begin bad++; $display("FAIL fidle_count got=%0d exp=0", bus.cycle_count); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL fidle_exit got=%0d exp=0", bus.state); end
    endtask

    task automatic test_run_halt();
        send(CMD_RUN);
        total++; if (bus.pipe_enable !== 1'b1) begin bad++; $display("FAIL run_enable got=%0d exp=1", bus.pipe_enable); end
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
        end
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL run_state got=%0d exp=1", bus.state); end
        total++; if (bus.cycle_count !== 4'd9) begin bad++; $display("FAIL run_count9 got=%0d exp=9", bus.cycle_count); end
        bus.halt_wb = 1'b1;
        @(posedge clk); #1;
        bus.halt_wb = 1'b0;
        total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL halt_state got=%0d exp=3", bus.state); end
        total++; if (bus.pipe_enable !== 1'b0) begin bad++; $display("FAIL halt_enable got=%0d exp=0", bus.pipe_enable); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL halt_done got=%0d exp=1", bus.done); end
        total++; if (bus.cycle_count !== 4'd10) begin bad++; $display("FAIL halt_count got=%0d exp=10", bus.cycle_count); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL halt_doneoff got=%0d exp=0", bus.done); end
        send(CMD_RUN);
        send(CMD_STEP);
        send(CMD_ABORT);
        total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL halt_sticky got=%0d exp=3", bus.state); end
        total++; if (bus.pipe_enable !== 1'b0) begin bad++; $display("FAIL halt_sticky_en got=%0d exp=0", bus.pipe_enable); end
        total++; if (bus.cycle_count !== 4'd10) begin bad++; $display("FAIL halt_sticky_cnt got=%0d exp=10", bus.cycle_count); end
    endtask

    task automatic test_flush_halted();
        send(CMD_FLUSH);
        for (int i = 0; i < 2; i++) begin
            total++; if (bus.pipe_flush !== 1'b1) begin bad++; $display("FAIL flush%0d_flush got=%0d exp=1", i, bus.pipe_flush); end
            total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL flush%0d_ready got=%0d exp=0", i, bus.cmd_rdy); end
            total++; if (bus.cycle_count !== 4'd0) begin bad++; $display("FAIL flush%0d_count got=%0d exp=0", i, bus.cycle_count); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL flush%0d_done got=%0d exp=0", i, bus.done); end
            @(posedge clk); #1;
        end
        total++; if (bus.pipe_flush !== 1'b0) begin bad++; $display("FAIL flush_end got=%0d exp=0", bus.pipe_flush); end
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL flush_idle got=%0d exp=0", bus.state); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0d exp=1", bus.cmd_rdy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL flush_done got=%0d exp=0", bus.done); end
    endtask

    task automatic test_abort();
        send(CMD_RUN);
        repeat (2) @(posedge clk);
        #1;
        bus.cmd_vld = 1'b1; bus.cmd_dat = CMD_ABORT; bus.halt_wb = 1'b1;
        @(posedge clk); #1;
        bus.cmd_vld = 1'b0; bus.cmd_dat = 8'h00; bus.halt_wb = 1'b0;
        total++; if (bus.state !== 3'd3) begin bad++; $display("FAIL abort_halt_state got=%0d exp=3", bus.state); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL abort_halt_done got=%0d exp=1", bus.done); end
        send(CMD_FLUSH);
        repeat (2) @(posedge clk);
        #1;
        send(CMD_RUN);
        repeat (2) @(posedge clk);
        #1;
        send(CMD_ABORT);
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", bus.state); end
        total++; if (bus.pipe_enable !== 1'b0) begin bad++; $display("FAIL abort_enable got=%0d exp=0", bus.pipe_enable); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0d exp=0", bus.done); end
        total++; if (bus.cycle_count !== 4'd3) begin bad++; $display("FAIL abort_count got=%0d exp=3", bus.cycle_count); end
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done2 got=%0d exp=0", bus.done); end
    endtask

    task automatic test_saturate_and_reset();
        send(CMD_RUN);
        repeat (11) @(posedge clk);
        #1;
        total++; if (bus.cycle_count !== 4'd14) begin bad++; $display("FAIL sat_count14 got=%0d exp=14", bus.cycle_count); end
        repeat (9) @(posedge clk);
        #1;
        total++; if (bus.cycle_count !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", bus.cycle_count); end
        total++; if (bus.state !== 3'd1) begin bad++; $display("FAIL sat_state got=%0d exp=1", bus.state); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.state !== 3'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", bus.state); end
        total++; if (bus.pipe_enable !== 1'b0) begin bad++; $display("FAIL arst_enable got=%0d exp=0", bus.pipe_enable); end
        total++; if (bus.pipe_flush !== 1'b0) begin bad++; $display("FAIL arst_flush got=%0d exp=0", bus.pipe_flush); end
        total++; if (bus.cycle_count !== 4'd0) begin bad++; $display("FAIL arst_count got=%0d exp=0", bus.cycle_count); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL arst_done got=%0d exp=0", bus.done); end
        total++; if (bus.cmd_rdy !== 1'b0) begin bad++; $display("FAIL arst_ready got=%0d exp=0", bus.cmd_rdy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL arst_after_done got=%0d exp=0", bus.done); end
        total++; if (bus.cmd_rdy !== 1'b1) begin bad++; $display("FAIL arst_after_ready got=%0d exp=1", bus.cmd_rdy); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_flush_idle();
        test_run_halt();
        test_flush_halted();
        test_abort();
        test_saturate_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
